// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-compatible PIC control path: strobe bit
// indices, command-word field positions, read-command encodings, ack states.
package pic_pkg;

  localparam int ICW1_IDX = 0;
  localparam int ICW2_IDX = 1;
  localparam int ICW3_IDX = 2;
  localparam int ICW4_IDX = 3;

  localparam int OCW1_IDX = 0;
  localparam int OCW2_IDX = 1;
  localparam int OCW3_IDX = 2;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW4_AEOI = 1;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;

  localparam logic [1:0] RC_IRR = 2'b10;
  localparam logic [1:0] RC_ISR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_WAIT = 2'd2,
    S_ACK2 = 2'd3
  } ack_state_t;

endpackage

// File: rtl/inta_sequencer.sv
// INTA synchroniser, edge detector and two-pulse acknowledge FSM.
// Entry strobes are combinational so the top can latch data on the same edge.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inta,
  input  logic abort,
  output logic ack1_entry,
  output logic ack2_entry,
  output logic in_ack1,
  output logic in_ack2,
  output logic busy,
  output logic first_ack,
  output logic second_ack
);

  ack_state_t state, state_nx;
  logic inta_s1, inta_s2, inta_s3;
  logic fall, rise;
  logic first_nx, second_nx;

  // Synchroniser resets to the idle (high) level so no edge is seen after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_s1 <= 1'b1;
      inta_s2 <= 1'b1;
      inta_s3 <= 1'b1;
    end else begin
      inta_s1 <= inta;
      inta_s2 <= inta_s1;
      inta_s3 <= inta_s2;
    end
  end

  assign fall = inta_s3 & ~inta_s2;
  assign rise = ~inta_s3 & inta_s2;

  always_comb begin
    state_nx   = state;
    first_nx   = 1'b0;
    second_nx  = 1'b0;
    ack1_entry = 1'b0;
    ack2_entry = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (fall) begin
          state_nx   = S_ACK1;
          first_nx   = 1'b1;
          ack1_entry = 1'b1;
        end
        S_ACK1: if (rise) state_nx = S_WAIT;
        S_WAIT: if (fall) begin
          state_nx   = S_ACK2;
          second_nx  = 1'b1;
          ack2_entry = 1'b1;
        end
        S_ACK2: if (rise) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      first_ack  <= 1'b0;
      second_ack <= 1'b0;
    end else begin
      state      <= state_nx;
      first_ack  <= first_nx;
      second_ack <= second_nx;
    end
  end

  assign in_ack1 = (state == S_ACK1);
  assign in_ack2 = (state == S_ACK2);
  assign busy    = (state != S_IDLE);

endmodule

// File: rtl/control_logic.sv
// PIC control core: ICW/OCW register file, vector generation and cascade bus
// handling around the INTA acknowledge sequencer.
module control_logic
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       SP,
  input  logic       INTA,
  input  logic [2:0] INT_VEC,
  input  logic [3:0] ICWs_Flags,
  input  logic [2:0] OCWs_Flags,
  input  logic [7:0] DATA_IN,
  inout  wire  [2:0] CAS,
  input  logic [7:0] IR,
  output logic [7:0] IM,
  output logic [1:0] Read_command,
  output logic       AEOI,
  output logic       LTIM,
  output logic [7:0] opperation_OCW2,
  output logic [7:0] IV,
  output logic       first_ACK,
  output logic       second_ACK,
  output logic       IV_ready
);

  logic       ic4, sngl;
  logic [4:0] t_base;
  logic [7:0] icw3;
  logic [2:0] vec;
  logic       cas_match;
  logic       cas_drive, iv_ok;
  logic       ack1_entry, ack2_entry, in_ack1, in_ack2, busy;

  inta_sequencer u_seq (
    .clk        (CLK),
    .rst_n      (RST_n),
    .inta       (INTA),
    .abort      (ICWs_Flags[ICW1_IDX]),
    .ack1_entry (ack1_entry),
    .ack2_entry (ack2_entry),
    .in_ack1    (in_ack1),
    .in_ack2    (in_ack2),
    .busy       (busy),
    .first_ack  (first_ACK),
    .second_ack (second_ACK)
  );

  // ICW strobes outrank OCW strobes; lowest set bit wins inside each group
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ic4             <= 1'b0;
      sngl            <= 1'b0;
      LTIM            <= 1'b0;
      t_base          <= '0;
      icw3            <= '0;
      AEOI            <= 1'b0;
      IM              <= '0;
      opperation_OCW2 <= '0;
      Read_command    <= RC_IRR;
    end else if (|ICWs_Flags) begin
      if (ICWs_Flags[ICW1_IDX]) begin
        ic4          <= DATA_IN[ICW1_IC4];
        sngl         <= DATA_IN[ICW1_SNGL];
        LTIM         <= DATA_IN[ICW1_LTIM];
        AEOI         <= 1'b0;
        IM           <= '0;
        Read_command <= RC_IRR;
      end else if (ICWs_Flags[ICW2_IDX]) begin
        t_base <= DATA_IN[7:3];
      end else if (ICWs_Flags[ICW3_IDX]) begin
        icw3 <= DATA_IN;
      end else if (ic4) begin
        AEOI <= DATA_IN[ICW4_AEOI];
      end
    end else if (OCWs_Flags[OCW1_IDX]) begin
      IM <= DATA_IN;
    end else if (OCWs_Flags[OCW2_IDX]) begin
      opperation_OCW2 <= DATA_IN;
    end else if (OCWs_Flags[OCW3_IDX] && DATA_IN[OCW3_RR]) begin
      Read_command <= {DATA_IN[OCW3_RR], DATA_IN[OCW3_RIS]};
    end
  end

  // Vector latch at ACK1 entry, slave ID compare during ACK1, IV load at ACK2
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vec       <= '0;
      cas_match <= 1'b0;
      IV        <= '0;
    end else begin
      if (ack1_entry) vec <= (IR == 8'd0) ? 3'b111 : INT_VEC;
      if (in_ack1)    cas_match <= (CAS == icw3[2:0]);
      if (ack2_entry) IV <= {t_base, vec};
    end
  end

  assign cas_drive = SP & ~sngl & busy & icw3[vec];
  assign CAS       = cas_drive ? vec : 3'bzzz;

  // A cascaded master defers the vector to the addressed slave
  assign iv_ok    = sngl | (SP ? ~icw3[vec] : cas_match);
  assign IV_ready = in_ack2 & iv_ok;

endmodule

// File: tb/tb_control_logic.sv
// Scoreboard bench for control_logic: a behavioural model predicts register
// contents and acknowledge responses; a monitor compares them as they appear.
module tb_control_logic;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       SP = 1'b1;
  logic       INTA = 1'b1;
  logic [2:0] INT_VEC = '0;
  logic [3:0] ICWs_Flags = '0;
  logic [2:0] OCWs_Flags = '0;
  logic [7:0] DATA_IN = '0;
  logic [7:0] IR = '0;
  wire  [2:0] CAS;
  logic       cas_en = 1'b0;
  logic [2:0] cas_drv = '0;
  logic [7:0] IM, opperation_OCW2, IV;
  logic [1:0] Read_command;
  logic       AEOI, LTIM, first_ACK, second_ACK, IV_ready;

  assign CAS = cas_en ? cas_drv : 3'bzzz;

  control_logic dut (
    .CLK(CLK), .RST_n(RST_n), .SP(SP), .INTA(INTA), .INT_VEC(INT_VEC),
    .ICWs_Flags(ICWs_Flags), .OCWs_Flags(OCWs_Flags), .DATA_IN(DATA_IN),
    .CAS(CAS), .IR(IR), .IM(IM), .Read_command(Read_command), .AEOI(AEOI),
    .LTIM(LTIM), .opperation_OCW2(opperation_OCW2), .IV(IV),
    .first_ACK(first_ACK), .second_ACK(second_ACK), .IV_ready(IV_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] im;
    logic [1:0] rc;
    logic       aeoi;
    logic       ltim;
    logic [7:0] ocw2;
  } reg_exp_t;

  typedef struct {
    bit         cas_z;
    logic [2:0] cas;
    logic [7:0] iv;
    logic       ready;
  } ack_exp_t;

  reg_exp_t reg_q[$];
  ack_exp_t ack1_q[$];
  ack_exp_t ack2_q[$];

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  bit       m_ic4 = 0, m_sngl = 0, m_ltim = 0, m_aeoi = 0;
  bit [4:0] m_t = '0;
  bit [7:0] m_icw3 = '0, m_im = '0, m_ocw2 = '0, m_iv = '0;
  bit [1:0] m_rc = 2'b10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Released bus reads as Z in a 4-state simulator and as 0 in a 2-state one
  task automatic check_cas(input string name, input bit exp_z, input logic [2:0] exp);
    bit ok;
    checks++;
    ok = exp_z ? ((CAS === 3'bzzz) || (CAS === 3'b000)) : (CAS === exp);
    if (ok) passes++;
    else if (exp_z) $display("FAIL %s: got CAS=%b expected released", name, CAS);
    else $display("FAIL %s: got CAS=%b expected %b", name, CAS, exp);
  endtask

  task automatic fail_unexpected(input string name);
    checks++;
    $display("FAIL %s: got an unexpected pulse expected none", name);
  endtask

  // Apply a strobe write to the model and issue it to the DUT for one cycle
  task automatic wr(input logic [3:0] icw, input logic [2:0] ocw, input logic [7:0] d);
    reg_exp_t e;
    if (icw != 4'd0) begin
      if (icw[0]) begin
        m_ic4 = d[0]; m_sngl = d[1]; m_ltim = d[3];
        m_im = 8'h00; m_rc = 2'b10; m_aeoi = 0;
      end else if (icw[1]) m_t = d[7:3];
      else if (icw[2]) m_icw3 = d;
      else if (m_ic4) m_aeoi = d[1];
    end else if (ocw[0]) m_im = d;
    else if (ocw[1]) m_ocw2 = d;
    else if (ocw[2] && d[1]) m_rc = d[1:0];
    e.im = m_im; e.rc = m_rc; e.aeoi = m_aeoi; e.ltim = m_ltim; e.ocw2 = m_ocw2;
    if ((icw != 4'd0) || (ocw != 3'd0)) reg_q.push_back(e);
    ICWs_Flags = icw; OCWs_Flags = ocw; DATA_IN = d;
    @(negedge CLK);
    ICWs_Flags = '0; OCWs_Flags = '0;
  endtask

  task automatic init_pic(input logic [7:0] i1, i2, i3, i4);
    wr(4'b0001, 3'b000, i1);
    wr(4'b0010, 3'b000, i2);
    wr(4'b0100, 3'b000, i3);
    wr(4'b1000, 3'b000, i4);
  endtask

  // Two-pulse INTA sequence; optionally reinitialise between the pulses
  task automatic inta_seq(input logic [7:0] ir, input logic [2:0] v1, input logic [2:0] v2,
                          input logic [2:0] cas_in, input bit abort_mid);
    ack_exp_t e;
    logic [2:0] vm;
    bit drive, ready;
    vm    = (ir == 8'd0) ? 3'b111 : v1;
    drive = SP && !m_sngl && m_icw3[vm];
    ready = m_sngl ? 1'b1 : (SP ? !m_icw3[vm] : (cas_in == m_icw3[2:0]));
    e.cas_z = SP ? !drive : 1'b0;
    e.cas   = SP ? vm : cas_in;
    e.iv    = m_iv;
    e.ready = 1'b0;
    ack1_q.push_back(e);
    IR = ir; INT_VEC = v1;
    if (!SP) begin cas_en = 1'b1; cas_drv = cas_in; end
    @(negedge CLK) INTA = 1'b0;
    repeat (6) @(negedge CLK);
    INTA = 1'b1; INT_VEC = v2;
    repeat (6) @(negedge CLK);
    if (abort_mid) begin
      wr(4'b0001, 3'b000, 8'hD5);
      repeat (4) @(negedge CLK);
      if (SP) check_cas("cas_after_abort", 1'b1, 3'b000);
      check("ready_after_abort", 32'(IV_ready), 32'd0);
      cas_en = 1'b0;
      return;
    end
    m_iv    = {m_t, vm};
    e.iv    = m_iv;
    e.ready = ready;
    ack2_q.push_back(e);
    INTA = 1'b0;
    repeat (6) @(negedge CLK);
    check("iv_ready_held", 32'(IV_ready), 32'(ready));
    INTA = 1'b1;
    repeat (6) @(negedge CLK);
    check("iv_ready_cleared", 32'(IV_ready), 32'd0);
    check("iv_holds", 32'(IV), 32'(m_iv));
    if (SP) check_cas("cas_released", 1'b1, 3'b000);
    cas_en = 1'b0;
    @(negedge CLK);
  endtask

  // Monitor: compare whatever the DUT presents against the queue heads
  logic wr_seen = 1'b0;
  logic prev_f = 1'b0, prev_s = 1'b0;

  always @(posedge CLK) wr_seen <= RST_n && ((ICWs_Flags != 4'd0) || (OCWs_Flags != 3'd0));

  always @(negedge CLK) begin
    if (RST_n) begin
      if (first_ACK) begin
        check("first_ack_width", 32'(prev_f), 32'd0);
        if (ack1_q.size() == 0) fail_unexpected("first_ack");
        else begin
          ack_exp_t e;
          e = ack1_q.pop_front();
          check_cas("cas_at_ack1", e.cas_z, e.cas);
        end
      end
      if (second_ACK) begin
        check("second_ack_width", 32'(prev_s), 32'd0);
        if (ack2_q.size() == 0) fail_unexpected("second_ack");
        else begin
          ack_exp_t e;
          e = ack2_q.pop_front();
          check("iv", 32'(IV), 32'(e.iv));
          check("iv_ready", 32'(IV_ready), 32'(e.ready));
          check_cas("cas_at_ack2", e.cas_z, e.cas);
        end
      end
      if (wr_seen) begin
        if (reg_q.size() == 0) fail_unexpected("reg_write");
        else begin
          reg_exp_t r;
          r = reg_q.pop_front();
          check("im", 32'(IM), 32'(r.im));
          check("read_command", 32'(Read_command), 32'(r.rc));
          check("aeoi", 32'(AEOI), 32'(r.aeoi));
          check("ltim", 32'(LTIM), 32'(r.ltim));
          check("ocw2", 32'(opperation_OCW2), 32'(r.ocw2));
        end
      end
    end
    prev_f <= first_ACK;
    prev_s <= second_ACK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_im", 32'(IM), 32'd0);
    check("rst_rc", 32'(Read_command), 32'd2);
    check("rst_aeoi", 32'(AEOI), 32'd0);
    check("rst_ltim", 32'(LTIM), 32'd0);
    check("rst_ocw2", 32'(opperation_OCW2), 32'd0);
    check("rst_iv", 32'(IV), 32'd0);
    check("rst_acks", 32'({first_ACK, second_ACK, IV_ready}), 32'd0);
    check_cas("rst_cas", 1'b1, 3'b000);
    RST_n = 1'b1;
    @(negedge CLK);

    // Single mode with ICW4
    SP = 1'b1;
    wr(4'b0001, 3'b000, 8'h1B);
    wr(4'b0010, 3'b000, 8'hE1);
    wr(4'b1000, 3'b000, 8'h02);
    wr(4'b0000, 3'b001, 8'hAA);
    wr(4'b0000, 3'b010, 8'h55);
    wr(4'b0000, 3'b100, 8'h33);
    wr(4'b0000, 3'b100, 8'h01);       // RR clear: read command holds
    wr(4'b0110, 3'b111, 8'h48);       // ICW2 outranks ICW3 and all OCWs
    wr(4'b0010, 3'b000, 8'hE1);
    wr(4'b0000, 3'b110, 8'h3C);       // OCW2 outranks OCW3
    inta_seq(8'h11, 3'd1, 3'd7, 3'b000, 1'b0);
    inta_seq(8'h00, 3'd3, 3'd4, 3'b000, 1'b0);

    // Cascade master, every IR line has a slave
    init_pic(8'hD5, 8'hE1, 8'hFF, 8'hDA);
    inta_seq(8'h11, 3'd1, 3'd1, 3'b000, 1'b0);
    inta_seq(8'h11, 3'd2, 3'd2, 3'b000, 1'b1);
    inta_seq(8'h04, 3'd2, 3'd5, 3'b000, 1'b0);
    wr(4'b0100, 3'b000, 8'h0F);
    inta_seq(8'h40, 3'd6, 3'd6, 3'b000, 1'b0);

    // Cascade slave with ID 2
    SP = 1'b0;
    init_pic(8'hD5, 8'hE1, 8'h02, 8'hDA);
    inta_seq(8'h04, 3'd2, 3'd2, 3'b010, 1'b0);
    inta_seq(8'h04, 3'd2, 3'd2, 3'b011, 1'b0);

    // Randomised modes, writes and acknowledge sequences
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ir_r;
      logic [2:0] cas_r;
      SP = 1'($urandom);
      init_pic(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int k = 0; k < 2; k++)
        wr(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(2, 15)),
           3'($urandom), 8'($urandom));
      ir_r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cas_r = ($urandom_range(0, 1) == 0) ? m_icw3[2:0] : 3'($urandom);
      inta_seq(ir_r, 3'($urandom), 3'($urandom), cas_r, 1'b0);
    end

    repeat (5) @(negedge CLK);
    check("ack1_queue_drained", 32'(ack1_q.size()), 32'd0);
    check("ack2_queue_drained", 32'(ack2_q.size()), 32'd0);
    check("reg_queue_drained", 32'(reg_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_logic.md
# control_logic

Control/acknowledge core of the 8259A-compatible PIC. It captures ICW1–ICW4 and OCW1–OCW3 writes from the read/write logic and exports the decoded mode bits. It tracks the two-pulse INTA acknowledge sequence and produces the interrupt vector. It also drives or decodes the cascade bus, and sits between the R/W decoder, priority resolver and data-bus buffer.

## Interface
Parameters: none.
- `CLK`  in  1  system clock; all state on rising edge
- `RST_n`  in  1  asynchronous, active-low reset
- `SP`  in  1  1 = master, 0 = slave
- `INTA`  in  1  interrupt acknowledge, active low, asynchronous to CLK (sampled)
- `INT_VEC`  in  3  resolved highest-priority IR number from priority resolver
- `ICWs_Flags`  in  4  one-hot write strobes ICW1..ICW4 (bit0 = ICW1)
- `OCWs_Flags`  in  3  one-hot write strobes OCW1..OCW3 (bit0 = OCW1)
- `DATA_IN`  in  8  data-bus byte accompanying a strobe
- `CAS`  inout  3  cascade bus; driven by master, read by slave, else Z
- `IR`  in  8  current interrupt request register
- `IM`  out  8  interrupt mask (OCW1)
- `Read_command`  out  2  OCW3 {RR,RIS}
- `AEOI`  out  1  ICW4 D1
- `LTIM`  out  1  ICW1 D3 (level-triggered)
- `opperation_OCW2`  out  8  last OCW2 byte, raw
- `IV`  out  8  interrupt vector
- `first_ACK`, `second_ACK`  out  1  one-cycle acknowledge pulses
- `IV_ready`  out  1  IV valid for data bus

## Operation
- Register writes occur on a CLK edge while a strobe bit is high. ICW strobes outrank OCW strobes. Within a group, the lowest set bit wins.
- ICW1 stores IC4 = D0, SNGL = D1 and LTIM = D3. It also clears IM, sets Read_command = 2'b10 and aborts any acknowledge sequence.
- ICW2 stores T[7:3] = D7:D3. ICW3 is stored whole; the master treats it as a slave-present bitmap, the slave uses D2:D0 as its ID.
- ICW4 sets AEOI = D1. If IC4 = 0, ICW4 fields stay 0.
- OCW1 sets IM = DATA_IN. OCW2 sets opperation_OCW2 = DATA_IN.
- OCW3 updates Read_command = D1:D0 only when D1 = 1; otherwise it holds.
- Acknowledge FSM states: IDLE → ACK1 (first INTA falling edge) → WAIT (INTA high) → ACK2 (second falling edge) → IDLE (INTA rises).
- A falling edge means previous sample 1 and current sample 0.
- At ACK1 entry, INT_VEC is latched as `vec`. If IR == 0 (spurious request), `vec` = 3'b111.
- At ACK2, IV = {T[7:3], vec}. `INT_VEC` changes after the latch are ignored.
- Cascade master (SP = 1, SNGL = 0): from ACK1 until IDLE, CAS = `vec` when ICW3[vec] = 1, else Z. When ICW3[vec] = 1, the master does not assert IV_ready (the slave supplies IV).
- Cascade slave (SP = 0, SNGL = 0): in ACK1 it compares CAS with ICW3[2:0]. It asserts IV_ready at ACK2 only on a match. CAS is never driven.
- Single mode: CAS = Z; IV_ready is asserted at every ACK2.

## Timing
- Reset values: IM = 0, Read_command = 2'b10, AEOI = 0, LTIM = 0, opperation_OCW2 = 0, IV = 0, first_ACK = 0, second_ACK = 0, IV_ready = 0, CAS = Z, FSM = IDLE, all ICW storage = 0.
- INTA is registered through two flops. An edge is detected one cycle after the second flop sees the change.
- first_ACK / second_ACK are high for exactly one CLK cycle, the cycle after edge detection.
- Register outputs update on the CLK edge that samples the strobe (1-cycle latency).
- IV and IV_ready become valid together with second_ACK. IV_ready clears on the cycle the INTA rising edge is detected; IV holds its value.
- A strobe write during an acknowledge sequence takes effect, except that ICW1 aborts the sequence (FSM → IDLE, CAS → Z).
- Reset mid-sequence returns everything to reset values asynchronously.

## Structure
- Shared package `pic_pkg`: ICW/OCW flag bit indices, ICW1/ICW4/OCW3 bit positions, Read_command encodings (IRR = 2'b10, ISR = 2'b11), FSM state enum.
- Natural sub-module: `inta_sequencer` (INTA synchroniser, edge detect, FSM, ACK pulses). Register file and cascade logic stay in the top.

## Test plan
- Reset, then write ICW1 = 0x1B, ICW2 = 0xE1, ICW4 = 0x02 → LTIM = 1, AEOI = 1, IM = 0, Read_command = 2'b10.
- With the single-mode setup above: OCW1 = 0xAA, OCW2 = 0x55, OCW3 = 0x33 → IM = 0xAA, opperation_OCW2 = 0x55, Read_command = 2'b11.
- Single mode, IR = 0x11, INT_VEC = 1 at the first INTA pulse, INT_VEC = 7 at the second → one first_ACK and one second_ACK pulse, IV = 0xE1, IV_ready high until INTA rises.
- Cascade master: ICW1 = 0xD5, ICW2 = 0xE1, ICW3 = 0xFF, ICW4 = 0xDA, INT_VEC = 1 → CAS = 3'b001 from ACK1 until INTA rises after ACK2, IV_ready stays 0.
- Slave: SP = 0, ICW3 = 0x02, external CAS = 3'b010 at ACK1, INT_VEC = 2 → IV = 0xE2, IV_ready = 1. Repeat with CAS = 3'b011 → IV_ready stays 0.
- IR = 0 at first INTA → IV = {T, 3'b111}. ICW1 write between the two INTA pulses → no second_ACK, CAS returns to Z.
